// File: rtl/map_pkg.sv
// Package shared by the map access controller, render and game logic.
// Holds the map geometry, the top-state encoding that means "playing",
// the controller FSM state type and the working-map row type.
package map_pkg;

  localparam int         MAP_W    = 64;    // cells per row, bit x = column x, 1 = wall
  localparam int         MAP_H    = 44;    // number of rows
  localparam logic [1:0] TOP_PLAY = 2'b10; // top-level state that starts/holds a game

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } map_state_t;

  typedef logic [MAP_W-1:0] map_row_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_req        per-requester request vector
//   i_advance    allows the priority pointer to move after a grant
//   o_gnt        one-hot grant (combinational), zero when no request
//   o_gnt_idx    index of the granted requester (0 when none)
// The search starts at the pointer; after a grant the pointer moves to the
// index just past the winner so the winner has lowest priority next time.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i_req,
  input  logic         i_advance,
  output logic [N-1:0] o_gnt,
  output logic [1:0]   o_gnt_idx
);

  logic [1:0] ptr_reg, ptr_next;
  logic       found;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && i_req[(int'(ptr_reg) + i) % N]) begin
        found                                = 1'b1;
        o_gnt[(int'(ptr_reg) + i) % N]       = 1'b1;
        o_gnt_idx                            = 2'((int'(ptr_reg) + i) % N);
      end
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (i_advance && found) begin
      ptr_next = (o_gnt_idx == 2'(N - 1)) ? 2'd0 : o_gnt_idx + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_reg <= '0;
    else        ptr_reg <= ptr_next;
  end

endmodule

// File: rtl/map_access_ctrl.sv
// Working-copy owner of the wall map.
// Bulk-loads the selected map one row per cycle when the top state rises into
// PLAY, then serves round-robin cell read/clear requests and a registered
// one-row-per-cycle render read port.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   i_top_state   top-level game state
//   i_map         source map, row y at [MAP_W*y +: MAP_W]
//   i_req/_clr    per-requester request and clear flag
//   i_req_x/_y    per-requester cell coordinates, 6 bits each
//   o_gnt         one-hot grant, same cycle as the request
//   o_rsp_*       response registered one cycle after the grant
//   i_row_addr    render row address
//   o_row_data    render row data (registered)
//   o_ready       high while serving requests
module map_access_ctrl
  import map_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             i_top_state,
  input  logic [MAP_W*MAP_H-1:0] i_map,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ-1:0]       i_req_clr,
  input  logic [6*N_REQ-1:0]     i_req_x,
  input  logic [6*N_REQ-1:0]     i_req_y,
  output logic [N_REQ-1:0]       o_gnt,
  output logic                   o_rsp_valid,
  output logic [1:0]             o_rsp_id,
  output logic                   o_rsp_bit,
  input  logic [5:0]             i_row_addr,
  output logic [MAP_W-1:0]       o_row_data,
  output logic                   o_ready
);

  map_state_t state_reg, state_next;
  logic [5:0] load_cnt_reg, load_cnt_next;
  logic [1:0] top_prev_reg;
  logic       load_we;
  logic       play, play_rise, run;

  logic [MAP_H-1:0][MAP_W-1:0] map_q;

  logic [1:0] gnt_idx;
  logic       any_gnt;
  logic [5:0] sel_x, sel_y;
  logic       sel_clr, in_range, clr_we;

  logic       rsp_valid_reg;
  logic [1:0] rsp_id_reg;
  logic       rsp_bit_reg;
  map_row_t   row_data_reg;

  assign play      = (i_top_state == TOP_PLAY);
  assign play_rise = play && (top_prev_reg != TOP_PLAY);
  assign run       = (state_reg == RUN);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      load_cnt_reg <= '0;
      top_prev_reg <= '0;
    end else begin
      state_reg    <= state_next;
      load_cnt_reg <= load_cnt_next;
      top_prev_reg <= i_top_state;
    end
  end

  always_comb begin
    state_next    = state_reg;
    load_cnt_next = load_cnt_reg;
    load_we       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (play_rise) begin
          state_next    = LOAD;
          load_cnt_next = '0;
        end
      end
      LOAD: begin
        // Leaving PLAY aborts without writing the current row.
        if (!play) begin
          state_next = IDLE;
        end else begin
          load_we = 1'b1;
          if (load_cnt_reg == 6'(MAP_H - 1)) begin
            state_next    = RUN;
            load_cnt_next = '0;
          end else begin
            load_cnt_next = load_cnt_reg + 6'd1;
          end
        end
      end
      RUN: begin
        if (!play) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- Arbitration ----------------
  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req & {N_REQ{run}}),
    .i_advance (run),
    .o_gnt     (o_gnt),
    .o_gnt_idx (gnt_idx)
  );

  assign any_gnt = |o_gnt;

  always_comb begin
    sel_x   = '0;
    sel_y   = '0;
    sel_clr = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_idx == 2'(k)) begin
        sel_x   = i_req_x[6*k +: 6];
        sel_y   = i_req_y[6*k +: 6];
        sel_clr = i_req_clr[k];
      end
    end
  end

  // Rows beyond the map read as wall and are never written.
  assign in_range = (sel_y < 6'(MAP_H));
  assign clr_we   = any_gnt && sel_clr && in_range;

  // ---------------- Working map ----------------
  // Plain flops per row: a load writes a whole row while a clear touches one bit.
  generate
    for (genvar gi = 0; gi < MAP_H; gi++) begin : g_row
      map_row_t row_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          row_reg <= '0;
        end else if (load_we && (load_cnt_reg == 6'(gi))) begin
          row_reg <= i_map[MAP_W*gi +: MAP_W];
        end else if (clr_we && (sel_y == 6'(gi))) begin
          row_reg[sel_x] <= 1'b0;
        end
      end
      assign map_q[gi] = row_reg;
    end
  endgenerate

  // ---------------- Response and render registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_bit_reg   <= 1'b0;
      row_data_reg  <= '0;
    end else begin
      rsp_valid_reg <= any_gnt;
      if (any_gnt) begin
        rsp_id_reg  <= gnt_idx;
        rsp_bit_reg <= in_range ? map_q[sel_y][sel_x] : 1'b1;
      end
      // Reads the pre-edge map, so a same-edge clear shows up one read later.
      row_data_reg <= (i_row_addr < 6'(MAP_H)) ? map_q[i_row_addr] : '0;
    end
  end

  assign o_rsp_valid = rsp_valid_reg;
  assign o_rsp_id    = rsp_id_reg;
  assign o_rsp_bit   = rsp_bit_reg;
  assign o_row_data  = row_data_reg;
  assign o_ready     = run;

endmodule
